// File: rtl/mem_arbiter_n_pkg.sv
// rtl/mem_arbiter_n_pkg.sv - shared state encoding and arbitration mode constants
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVICE,
    ARB_RELAX
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_arbiter_n_if.sv
// rtl/mem_arbiter_n_if.sv - upstream request bundle and downstream memory bus
interface mem_arbiter_n_req_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [N_PORTS*ADDR_W-1:0] req_addr;
  logic [N_PORTS*DATA_W-1:0] req_data_i;
  logic [N_PORTS*BE_W-1:0]   req_data_en;
  logic [N_PORTS-1:0]        req_read_en;
  logic [N_PORTS-1:0]        req_write_en;
  logic [N_PORTS*DATA_W-1:0] req_data_o;
  logic [N_PORTS-1:0]        req_hit;
  logic [N_PORTS-1:0]        req_done;

  modport master (
    output req_addr, req_data_i, req_data_en, req_read_en, req_write_en,
    input  req_data_o, req_hit, req_done
  );

  modport slave (
    input  req_addr, req_data_i, req_data_en, req_read_en, req_write_en,
    output req_data_o, req_hit, req_done
  );
endinterface

interface mem_arbiter_n_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_i;
  logic [BE_W-1:0]   mem_data_en;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_hit;
  logic              mem_done;

  modport master (
    output mem_addr, mem_data_i, mem_data_en, mem_read_en, mem_write_en,
    input  mem_data_o, mem_hit, mem_done
  );

  modport slave (
    input  mem_addr, mem_data_i, mem_data_en, mem_read_en, mem_write_en,
    output mem_data_o, mem_hit, mem_done
  );
endinterface

// File: rtl/mem_arbiter_n_rr_pick.sv
// rtl/mem_arbiter_n_rr_pick.sv - combinational fixed/round-robin requester picker
module rr_pick #(
  parameter  int N_PORTS = 4,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               rr_mode_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*N_PORTS-1:0] dbl;
  logic [2*N_PORTS-1:0] masked;
  logic [IDX_W:0]       start;

  // Start at ptr+1 in the doubled vector; the upper copy supplies the wrap-around.
  assign start = rr_mode_i ? ({1'b0, ptr_i} + (IDX_W+1)'(1)) : '0;
  assign dbl   = {req_i, req_i};

  always_comb begin
    masked  = '0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < 2*N_PORTS; k++) begin
      masked[k] = dbl[k] && (k >= int'(start));
    end
    for (int k = 2*N_PORTS-1; k >= 0; k--) begin
      if (masked[k]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((k >= N_PORTS) ? (k - N_PORTS) : k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-port memory arbiter onto a single downstream port
module mem_arbiter_n
  import mem_arb_pkg::*;
#(
  parameter  int N_PORTS  = 4,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int ARB_MODE = 1,
  parameter  int RELAX_EN = 1,
  localparam int IDX_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_arbiter_n_req_if.slave req,
  mem_arbiter_n_mem_if.master mem,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_PORTS-1:0]  done_q, done_d;
  logic [N_PORTS-1:0]  req_vec;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                service;

  logic [ADDR_W-1:0]         addr_c;
  logic [DATA_W-1:0]         wdata_c;
  logic [BE_W-1:0]           be_c;
  logic                      rd_c, wr_c;
  logic [N_PORTS*DATA_W-1:0] rdata_c;
  logic [N_PORTS-1:0]        hit_c;

  assign req_vec = req.req_read_en | req.req_write_en;
  assign service = (state_q == ARB_SERVICE);

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .req_i     (req_vec),
    .ptr_i     (rr_ptr_q),
    .rr_mode_i (ARB_MODE == ARB_RR),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= IDX_W'(N_PORTS - 1);
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_SERVICE;
          grant_d = pick_idx;
        end
      end
      ARB_SERVICE: begin
        // Only mem_done ends a transaction; requesters cannot withdraw mid-flight.
        if (mem.mem_done) begin
          state_d  = (RELAX_EN != 0) ? ARB_RELAX : ARB_IDLE;
          rr_ptr_d = grant_q;
        end
      end
      ARB_RELAX: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    done_d  = '0;
    addr_c  = '0;
    wdata_c = '0;
    be_c    = '0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    rdata_c = '0;
    hit_c   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (service && (grant_q == IDX_W'(i))) begin
        done_d[i]                   = mem.mem_hit;
        addr_c                      = req.req_addr[i*ADDR_W +: ADDR_W];
        wdata_c                     = req.req_data_i[i*DATA_W +: DATA_W];
        be_c                        = req.req_data_en[i*BE_W +: BE_W];
        rd_c                        = req.req_read_en[i];
        wr_c                        = req.req_write_en[i];
        rdata_c[i*DATA_W +: DATA_W] = mem.mem_data_o;
        hit_c[i]                    = mem.mem_hit;
      end
    end
  end

  assign mem.mem_addr     = addr_c;
  assign mem.mem_data_i   = wdata_c;
  assign mem.mem_data_en  = be_c;
  assign mem.mem_read_en  = rd_c;
  assign mem.mem_write_en = wr_c;
  assign req.req_data_o   = rdata_c;
  assign req.req_hit      = hit_c;
  assign req.req_done     = done_q;
  assign grant_valid      = service;
  assign grant_idx        = service ? grant_q : '0;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - table-driven bench over RR, fixed and no-relax arbiter builds
module tb_mem_arbiter_n;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    t_rd, t_wr;
  logic            t_hit, t_done;
  logic [DW-1:0]   t_mdata;
  logic [N*AW-1:0] t_addr;
  logic [N*DW-1:0] t_wdata;
  logic [N*BW-1:0] t_be;

  logic            o_gv   [3];
  logic [1:0]      o_gi   [3];
  logic            o_rd   [3];
  logic            o_wr   [3];
  logic [AW-1:0]   o_addr [3];
  logic [DW-1:0]   o_wdata[3];
  logic [BW-1:0]   o_be   [3];
  logic [N-1:0]    o_hit  [3];
  logic [N-1:0]    o_done [3];
  logic [N*DW-1:0] o_dout [3];

  // Instance 0: round robin + relax, 1: fixed priority + relax, 2: round robin, no relax.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter_n_req_if #(.N_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) rq ();
    mem_arbiter_n_mem_if #(.ADDR_W(AW), .DATA_W(DW)) mb ();

    assign rq.req_addr     = t_addr;
    assign rq.req_data_i   = t_wdata;
    assign rq.req_data_en  = t_be;
    assign rq.req_read_en  = t_rd;
    assign rq.req_write_en = t_wr;
    assign mb.mem_data_o   = t_mdata;
    assign mb.mem_hit      = t_hit;
    assign mb.mem_done     = t_done;

    assign o_rd[g]    = mb.mem_read_en;
    assign o_wr[g]    = mb.mem_write_en;
    assign o_addr[g]  = mb.mem_addr;
    assign o_wdata[g] = mb.mem_data_i;
    assign o_be[g]    = mb.mem_data_en;
    assign o_hit[g]   = rq.req_hit;
    assign o_done[g]  = rq.req_done;
    assign o_dout[g]  = rq.req_data_o;

    mem_arbiter_n #(
      .N_PORTS (N),
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .ARB_MODE((g == 1) ? 0 : 1),
      .RELAX_EN((g == 2) ? 0 : 1)
    ) u_dut (
      .clk        (clk),
      .reset      (rst),
      .req        (rq),
      .mem        (mb),
      .grant_valid(o_gv[g]),
      .grant_idx  (o_gi[g])
    );
  end

  typedef struct {
    int          dut;
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        hit;
    logic        done;
    logic [31:0] mdata;
    logic        e_gv;
    logic [1:0]  e_gi;
    logic [3:0]  e_done;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input int d, input logic r, input logic [3:0] rd, input logic [3:0] wr,
                     input logic h, input logic dn, input logic gv, input logic [1:0] gi,
                     input logic [3:0] dne);
    vec_t v;
    v.dut    = d;
    v.rst    = r;
    v.rd     = rd;
    v.wr     = wr;
    v.hit    = h;
    v.done   = dn;
    v.mdata  = 32'hC0DE_0000 + 32'(tbl.size());
    v.e_gv   = gv;
    v.e_gi   = gi;
    v.e_done = dne;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input int row, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic run_row(input int k);
    vec_t         v;
    int           d;
    int           g;
    logic [127:0] e_dout;
    logic [3:0]   e_hit;
    v = tbl[k];
    d = v.dut;
    g = int'(v.e_gi);
    @(posedge clk);
    #1;
    rst     = v.rst;
    t_rd    = v.rd;
    t_wr    = v.wr;
    t_hit   = v.hit;
    t_done  = v.done;
    t_mdata = v.mdata;
    #1;
    if (!v.rst) begin
      e_dout = v.e_gv ? (128'(v.mdata) << (32 * g)) : 128'd0;
      e_hit  = (v.e_gv && v.hit) ? (4'b0001 << g) : 4'b0000;
      cmp("grant_valid", k, 128'(o_gv[d]), 128'(v.e_gv));
      cmp("grant_idx",   k, 128'(o_gi[d]), 128'(v.e_gi));
      cmp("req_done",    k, 128'(o_done[d]), 128'(v.e_done));
      cmp("req_hit",     k, 128'(o_hit[d]), 128'(e_hit));
      cmp("req_data_o",  k, 128'(o_dout[d]), e_dout);
      cmp("mem_read_en", k, 128'(o_rd[d]), 128'(v.e_gv ? v.rd[g] : 1'b0));
      cmp("mem_write_en", k, 128'(o_wr[d]), 128'(v.e_gv ? v.wr[g] : 1'b0));
      cmp("mem_addr",    k, 128'(o_addr[d]), 128'(v.e_gv ? t_addr[g*AW +: AW] : 32'd0));
      cmp("mem_data_i",  k, 128'(o_wdata[d]), 128'(v.e_gv ? t_wdata[g*DW +: DW] : 32'd0));
      cmp("mem_data_en", k, 128'(o_be[d]), 128'(v.e_gv ? t_be[g*BW +: BW] : 4'd0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    rst     = 1'b1;
    t_rd    = '0;
    t_wr    = '0;
    t_hit   = 1'b0;
    t_done  = 1'b0;
    t_mdata = '0;
    t_addr  = {32'h0000_3000, 32'h0000_0100, 32'h0000_2000, 32'h0000_1000};
    t_wdata = {32'hDA7A_0003, 32'hDA7A_0002, 32'hDA7A_0001, 32'hDA7A_0000};
    t_be    = {4'hC, 4'h3, 4'hF, 4'h1};

    // Single read on port 2, hit+done on the third SERVICE cycle.
    add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h4, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h4, 4'h0, 0, 0, 1, 2, 4'h0);
    add(0, 0, 4'h4, 4'h0, 0, 0, 1, 2, 4'h0);
    add(0, 0, 4'h4, 4'h0, 1, 1, 1, 2, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h4);
    add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    // Round robin with all four requesting (port 3 writes): 0,1,2,3,0.
    add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 1, 1, 1, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h1);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 1, 1, 1, 1, 4'h0);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h2);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 1, 1, 1, 2, 4'h0);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h4);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 1, 1, 1, 3, 4'h0);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h8);
    add(0, 0, 4'h7, 4'h8, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h7, 4'h8, 1, 1, 1, 0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h1);
    // Fixed priority, ports 1 and 3 requesting: port 1 every time.
    add(1, 1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'hA, 4'h0, 1, 1, 1, 1, 4'h0);
    add(1, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h2);
    add(1, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'hA, 4'h0, 1, 1, 1, 1, 4'h0);
    add(1, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h2);
    add(1, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0);
    add(1, 0, 4'hA, 4'h0, 1, 1, 1, 1, 4'h0);
    add(1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h2);
    // Port 3 served, then 0 and 3 together: 0 then 3; port 3 drops enables mid-service.
    add(0, 1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h8, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h8, 4'h0, 1, 1, 1, 3, 4'h0);
    add(0, 0, 4'h9, 4'h0, 0, 0, 0, 0, 4'h8);
    add(0, 0, 4'h9, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h9, 4'h0, 1, 1, 1, 0, 4'h0);
    add(0, 0, 4'h9, 4'h0, 0, 0, 0, 0, 4'h1);
    add(0, 0, 4'h9, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 0, 1, 3, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 0, 1, 3, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 1, 1, 3, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    // No relax cycle: done pulses in IDLE while the next grant is taken.
    add(2, 1, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(2, 0, 4'h3, 4'h0, 0, 0, 0, 0, 4'h0);
    add(2, 0, 4'h3, 4'h0, 1, 1, 1, 0, 4'h0);
    add(2, 0, 4'h3, 4'h0, 0, 0, 0, 0, 4'h1);
    add(2, 0, 4'h3, 4'h0, 1, 1, 1, 1, 4'h0);
    add(2, 0, 4'h3, 4'h0, 0, 0, 0, 0, 4'h2);
    add(2, 0, 4'h3, 4'h0, 0, 0, 1, 0, 4'h0);
    add(2, 0, 4'h0, 4'h0, 0, 1, 1, 0, 4'h0);
    add(2, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0);

    for (int k = 0; k < tbl.size(); k++) run_row(k);

    // Reset in the middle of a port-1 write, with a hit pending.
    @(posedge clk); #1;
    rst = 1'b1; t_rd = '0; t_wr = '0; t_hit = 1'b0; t_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; t_wr = 4'b0010;
    @(posedge clk); #1;
    t_hit = 1'b1;
    #1;
    cmp("midrst_grant_valid", -1, 128'(o_gv[0]), 128'd1);
    cmp("midrst_grant_idx",   -1, 128'(o_gi[0]), 128'd1);
    cmp("midrst_write_en",    -1, 128'(o_wr[0]), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; t_hit = 1'b0; t_rd = 4'b0001;
    #1;
    cmp("postrst_write_en",    -1, 128'(o_wr[0]), 128'd0);
    cmp("postrst_req_done",    -1, 128'(o_done[0]), 128'd0);
    cmp("postrst_grant_valid", -1, 128'(o_gv[0]), 128'd0);
    n = 0;
    while (!o_gv[0] && n < 8) begin
      @(posedge clk); #2;
      n++;
    end
    cmp("postrst_grant_latency", -1, 128'(n), 128'd1);
    cmp("postrst_grant_idx",     -1, 128'(o_gi[0]), 128'd0);
    t_rd = '0; t_wr = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
